// File: rtl/bram_frame_ctrl_if.sv
// BRAM port and PC read port of the frame controller, bundled as one interface.
// master = controller side, slave = BRAM plus PC requester side.
interface bram_frame_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [7:0]        bram_din;
    logic [7:0]        bram_dout;

    logic              pc_ready;
    logic              pc_req;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_valid;
    logic [7:0]        pc_data;

    modport master (
        output bram_addr, bram_we, bram_din,
        input  bram_dout,
        output pc_ready, pc_valid, pc_data,
        input  pc_req, pc_addr
    );

    modport slave (
        input  bram_addr, bram_we, bram_din,
        output bram_dout,
        input  pc_ready, pc_valid, pc_data,
        output pc_req, pc_addr
    );
endinterface

// File: rtl/bram_frame_ctrl.sv
// Frame BRAM sequencer: captures one active frame in 3-3-2 format, then serves
// reads to the display path or to the PC requester.
module bram_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int ADDR_W   = 18   // H_ACTIVE*V_ACTIVE must fit in 2**ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           fsm_state,
    input  logic                 capture_start,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic [23:0]          pixel_in,
    output logic [1:0]           bram_state,
    output logic                 frame_done,
    output logic                 in_display,
    bram_frame_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        BRAM_IDLE     = 2'b00,
        CAPTURE_FRAME = 2'b01,
        WRITING_FRAME = 2'b10,
        READING_FRAME = 2'b11
    } state_t;

    localparam logic [2:0]        FSM_IDLE     = 3'b000;
    localparam logic [2:0]        SAVE_TO_BRAM = 3'b100;
    localparam logic [2:0]        SEND_TO_PC   = 3'b101;
    localparam logic [10:0]       H_LIM        = 11'(H_ACTIVE);
    localparam logic [9:0]        V_LIM        = 10'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_cnt;
    logic              disp_p1;
    logic              pc_p1;

    logic              active;
    logic              origin;
    logic              save_mode;
    logic              pc_mode;
    logic              cap_req;
    logic [7:0]        packed_px;
    logic [ADDR_W-1:0] wr_slot;

    assign active    = (hcount < H_LIM) && (vcount < V_LIM);
    assign origin    = (hcount == '0) && (vcount == '0);
    assign save_mode = (fsm_state == SAVE_TO_BRAM);
    assign pc_mode   = (fsm_state == SEND_TO_PC);
    assign cap_req   = capture_start && save_mode;
    assign packed_px = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};
    // The first write of a frame always lands at address 0, on the origin pixel.
    assign wr_slot   = (state == CAPTURE_FRAME) ? '0 : wr_addr;

    assign bram_state  = state;
    // BRAM data is valid in the cycle pc_valid is high; pass it straight through.
    assign bus.pc_data = bus.pc_valid ? bus.bram_dout : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= BRAM_IDLE;
            wr_addr        <= '0;
            rd_cnt         <= '0;
            disp_p1        <= 1'b0;
            pc_p1          <= 1'b0;
            frame_done     <= 1'b0;
            in_display     <= 1'b0;
            bus.bram_addr  <= '0;
            bus.bram_we    <= 1'b0;
            bus.bram_din   <= 8'h00;
            bus.pc_ready   <= 1'b0;
            bus.pc_valid   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first, so every pulse output drops unless re-asserted below.
            bus.bram_we  <= 1'b0;
            frame_done   <= 1'b0;
            disp_p1      <= 1'b0;
            pc_p1        <= 1'b0;
            bus.pc_ready <= 1'b0;
            in_display   <= disp_p1;
            bus.pc_valid <= pc_p1;

            case (state)
                BRAM_IDLE: begin
                    if (cap_req)
                        state <= CAPTURE_FRAME;
                end

                CAPTURE_FRAME, WRITING_FRAME: begin
                    if (!save_mode) begin
                        state <= BRAM_IDLE;
                    end else if (capture_start) begin
                        state <= CAPTURE_FRAME;
                    end else if ((state == CAPTURE_FRAME) ? origin : active) begin
                        bus.bram_we   <= 1'b1;
                        bus.bram_addr <= wr_slot;
                        bus.bram_din  <= packed_px;
                        wr_addr       <= wr_slot + 1'b1;
                        if (wr_slot == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            rd_cnt     <= '0;
                            state      <= READING_FRAME;
                        end else begin
                            state <= WRITING_FRAME;
                        end
                    end
                end

                READING_FRAME: begin
                    if (fsm_state == FSM_IDLE) begin
                        state <= BRAM_IDLE;
                    end else if (cap_req) begin
                        state <= CAPTURE_FRAME;
                    end else if (pc_mode) begin
                        bus.pc_ready <= 1'b1;
                        if (bus.pc_req) begin
                            bus.bram_addr <= bus.pc_addr;
                            pc_p1         <= 1'b1;
                        end
                    end else if (active) begin
                        disp_p1       <= 1'b1;
                        bus.bram_addr <= origin ? '0 : rd_cnt;
                        rd_cnt        <= origin ? ADDR_W'(1) : rd_cnt + 1'b1;
                    end
                end

                default: state <= BRAM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// Directed bench for bram_frame_ctrl on an 8x4 active frame inside a 12x6 raster,
// with a behavioural BRAM that can also act as an addr+1 ROM.
module tb_bram_frame_ctrl;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int AW     = 18;
    localparam int H_TOT  = 12;
    localparam int V_TOT  = 6;
    localparam int FRAME  = H_TOT * V_TOT;
    localparam int NPIX   = H * V;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  din;
    } pack_vec_t;

    pack_vec_t tbl [8];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  fsm_state = 3'b000;
    logic        capture_start = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [23:0] pixel_in = '0;
    logic [1:0]  bram_state;
    logic        frame_done;
    logic        in_display;

    bit          rom_mode;
    int          pix_mode;
    int          h, v;
    int          n_checks, n_fail;
    logic [7:0]  mem [64];

    bram_frame_ctrl_if #(.ADDR_W(AW)) bus ();

    bram_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .fsm_state     (fsm_state),
        .capture_start (capture_start),
        .hcount        (hcount),
        .vcount        (vcount),
        .pixel_in      (pixel_in),
        .bram_state    (bram_state),
        .frame_done    (frame_done),
        .in_display    (in_display),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    // Single-port read-first BRAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.bram_we)
            mem[bus.bram_addr[5:0]] <= bus.bram_din;
        bus.bram_dout <= rom_mode ? bus.bram_addr[7:0] + 8'd1 : mem[bus.bram_addr[5:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pix_of(input int hh, input int vv);
        if (hh >= H || vv >= V) return 24'h0;
        if (pix_mode == 0) return (hh == 0 && vv == 0) ? 24'hE0E0C0 : 24'h0;
        return tbl[(vv * H + hh) % 8].pix;
    endfunction

    function automatic logic [7:0] din_of(input int k);
        if (pix_mode == 0) return (k == 0) ? 8'hFF : 8'h00;
        return tbl[k % 8].din;
    endfunction

    // Present the next raster pixel, clock it in, sample just after the edge.
    task automatic tick();
        hcount   = 11'(h);
        vcount   = 10'(v);
        pixel_in = pix_of(h, v);
        @(posedge clk);
        #1;
        h++;
        if (h == H_TOT) begin
            h = 0;
            v++;
            if (v == V_TOT) v = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " bram_state"}, 32'(bram_state), 32'd0);
        check({tag, " bram_addr"},  32'(bus.bram_addr), 32'd0);
        check({tag, " bram_we"},    32'(bus.bram_we), 32'd0);
        check({tag, " bram_din"},   32'(bus.bram_din), 32'd0);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
        check({tag, " in_display"}, 32'(in_display), 32'd0);
        check({tag, " pc_ready"},   32'(bus.pc_ready), 32'd0);
        check({tag, " pc_valid"},   32'(bus.pc_valid), 32'd0);
        check({tag, " pc_data"},    32'(bus.pc_data), 32'd0);
    endtask

    task automatic pulse_capture();
        if (h == 0 && v == 0) tick();
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
        check("state after capture_start", 32'(bram_state), 32'd1);
        check("no write after capture_start", 32'(bus.bram_we), 32'd0);
    endtask

    // Follows a capture write by write until stop_at writes have been seen.
    task automatic run_capture(input int stop_at);
        bit armed = 1'b0;
        bit exp_we;
        int nw = 0;
        int ph, pv, exp_state;
        for (int c = 0; c < 3 * FRAME && nw < stop_at; c++) begin
            ph = h;
            pv = v;
            tick();
            if (ph == 0 && pv == 0) armed = 1'b1;
            exp_we = armed && ph < H && pv < V;
            check("bram_we", 32'(bus.bram_we), 32'(exp_we));
            check("frame_done", 32'(frame_done), 32'(exp_we && nw == NPIX - 1));
            if (exp_we) begin
                check("bram_addr", 32'(bus.bram_addr), 32'(nw));
                check("bram_din", 32'(bus.bram_din), 32'(din_of(nw)));
                nw++;
            end
            exp_state = !armed ? 1 : (nw == NPIX ? 3 : 2);
            check("bram_state", 32'(bram_state), 32'(exp_state));
        end
        if (nw < stop_at) check("capture write count", 32'(nw), 32'(stop_at));
    endtask

    initial begin
        int ph, pv, prev_idx, highs;
        bit prev_act;
        logic [7:0] exp_pc [3];

        tbl[0] = '{24'hE0E0C0, 8'hFF};
        tbl[1] = '{24'h000000, 8'h00};
        tbl[2] = '{24'hFF0000, 8'hE0};
        tbl[3] = '{24'h00FF00, 8'h1C};
        tbl[4] = '{24'h0000FF, 8'h03};
        tbl[5] = '{24'h1F1F3F, 8'h00};
        tbl[6] = '{24'hA05040, 8'hA9};
        tbl[7] = '{24'h20C080, 8'h3A};

        bus.pc_req  = 1'b0;
        bus.pc_addr = '0;
        rom_mode    = 1'b0;
        pix_mode    = 0;
        h = 0;
        v = 0;

        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // capture_start outside SAVE_TO_BRAM is ignored
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
        check("capture ignored in idle fsm", 32'(bram_state), 32'd0);

        // Full capture started mid-frame
        fsm_state = 3'b100;
        for (int i = 0; i < FRAME && !(v == 2 && h == 3); i++) tick();
        pulse_capture();
        run_capture(NPIX);

        // Display readback from an addr+1 ROM, two frames
        rom_mode = 1'b1;
        for (int i = 0; i < FRAME && !(h == 0 && v == 0); i++) tick();
        prev_act = 1'b0;
        prev_idx = 0;
        for (int f = 0; f < 2; f++) begin
            highs = 0;
            for (int c = 0; c < FRAME; c++) begin
                ph = h;
                pv = v;
                tick();
                check("in_display", 32'(in_display), 32'(prev_act));
                if (prev_act) begin
                    check("display bram_dout", 32'(bus.bram_dout), 32'(prev_idx + 1));
                    highs++;
                end
                prev_act = ph < H && pv < V;
                prev_idx = pv * H + ph;
            end
            check("display reads per frame", 32'(highs), 32'(NPIX));
        end

        // PC mode: three back-to-back requests
        fsm_state = 3'b101;
        tick();
        tick();
        check("pc_ready", 32'(bus.pc_ready), 32'd1);
        exp_pc = '{8'd6, 8'd7, 8'd8};
        for (int i = 0; i < 5; i++) begin
            bus.pc_req  = (i < 3);
            bus.pc_addr = AW'(5 + i);
            tick();
            check("pc in_display", 32'(in_display), 32'd0);
            check("pc_valid", 32'(bus.pc_valid), 32'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3)
                check("pc_data", 32'(bus.pc_data), 32'(exp_pc[i - 1]));
        end
        bus.pc_req = 1'b0;

        // Idle exit; pc_req is then ignored
        fsm_state = 3'b000;
        tick();
        check("idle exit state", 32'(bram_state), 32'd0);
        bus.pc_req = 1'b1;
        tick();
        tick();
        tick();
        bus.pc_req = 1'b0;
        check("pc_ready outside pc mode", 32'(bus.pc_ready), 32'd0);
        check("pc_req ignored", 32'(bus.pc_valid), 32'd0);

        // Abort after 10 writes
        rom_mode  = 1'b0;
        fsm_state = 3'b100;
        pulse_capture();
        run_capture(10);
        fsm_state = 3'b000;
        tick();
        check("abort state", 32'(bram_state), 32'd0);
        check("abort bram_we", 32'(bus.bram_we), 32'd0);
        check("abort frame_done", 32'(frame_done), 32'd0);
        tick();
        check("abort bram_we later", 32'(bus.bram_we), 32'd0);

        // Reset at write 15, then a full recapture with the packing table
        fsm_state = 3'b100;
        pulse_capture();
        run_capture(15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("mid-write reset");
        pix_mode = 1;
        pulse_capture();
        run_capture(NPIX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
